// File: rtl/wait_state_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : wait_state_gen_if
// Brief   : Status / I/O-channel / ready-request bundle of the wait-state
//           generator. The master side drives CPU status and channel
//           signals; the slave side is the wait-state generator itself.
// Revision: 1.0 - initial release
// ============================================================================
interface wait_state_gen_if;
  logic [2:0] s;            // 8088 status S2..S0, 3'b111 = passive
  logic       io_ch_rdy;    // I/O channel ready, low requests extension
  logic       dma_active;   // DMA controller owns the bus
  logic       rdy1;         // ready request to the 8284A, active-high
  logic       aen1;         // ready enable to the 8284A, active-low
  logic       wait_active;  // rdy1 held low by the generator
  logic [2:0] cycle_type;   // status code latched at cycle start
  logic       bus_timeout;  // one-clock pulse on extension timeout

  modport master (
    output s, io_ch_rdy, dma_active,
    input  rdy1, aen1, wait_active, cycle_type, bus_timeout
  );

  modport slave (
    input  s, io_ch_rdy, dma_active,
    output rdy1, aen1, wait_active, cycle_type, bus_timeout
  );
endinterface
`default_nettype wire

// File: rtl/wait_state_gen.sv
`default_nettype none
// ============================================================================
// Module  : wait_state_gen
// Brief   : Bus-cycle wait-state generator for the 8284A RDY1/AEN1 inputs.
//           Detects each new 8088 bus cycle, holds rdy1 low for the cycle
//           type's forced wait count, then extends while the I/O channel
//           requests it, bounded by a timeout.
// Revision: 1.0 - initial release
// ============================================================================
module wait_state_gen #(
  parameter int IO_WAITS   = 1,
  parameter int MEM_WAITS  = 0,
  parameter int INTA_WAITS = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  wait_state_gen_if.slave   bus
);

  localparam logic [2:0] c_s_inta    = 3'b000;
  localparam logic [2:0] c_s_ior     = 3'b001;
  localparam logic [2:0] c_s_iow     = 3'b010;
  localparam logic [2:0] c_s_halt    = 3'b011;
  localparam logic [2:0] c_s_code    = 3'b100;
  localparam logic [2:0] c_s_memr    = 3'b101;
  localparam logic [2:0] c_s_memw    = 3'b110;
  localparam logic [2:0] c_s_passive = 3'b111;

  localparam logic [3:0] c_io_waits   = 4'(IO_WAITS);
  localparam logic [3:0] c_mem_waits  = 4'(MEM_WAITS);
  localparam logic [3:0] c_inta_waits = 4'(INTA_WAITS);
  localparam logic [7:0] c_timeout    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_EXTEND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_s_prev;
  logic [3:0] r_count;
  logic [7:0] r_timer;
  logic       r_rdy1;
  logic       r_aen1;
  logic       r_wait_active;
  logic [2:0] r_cycle_type;
  logic       r_bus_timeout;

  state_t     w_state_nxt;
  logic [3:0] w_count_nxt;
  logic [7:0] w_timer_nxt;
  logic       w_rdy1_nxt;
  logic       w_wait_active_nxt;
  logic [2:0] w_cycle_type_nxt;
  logic       w_bus_timeout_nxt;
  logic       w_cycle_start;
  logic [3:0] w_start_waits;
  logic [7:0] w_timer_inc;

  // Forced wait count for the status code presented at cycle start.
  function automatic logic [3:0] waits_for(input logic [2:0] code);
    case (code)
      c_s_inta:                     waits_for = c_inta_waits;
      c_s_ior, c_s_iow:             waits_for = c_io_waits;
      c_s_code, c_s_memr, c_s_memw: waits_for = c_mem_waits;
      default:                      waits_for = 4'd0;
    endcase
  endfunction

  // A cycle starts only on a passive -> active transition; HALT never waits.
  assign w_cycle_start = (r_state == ST_IDLE) && (r_s_prev == c_s_passive) &&
                         (bus.s != c_s_passive) && (bus.s != c_s_halt);
  assign w_start_waits = waits_for(bus.s);
  assign w_timer_inc   = r_timer + 8'd1;

  // Next-state and next-output decode for the wait-state sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_timer_nxt       = r_timer;
    w_rdy1_nxt        = r_rdy1;
    w_cycle_type_nxt  = r_cycle_type;
    w_bus_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rdy1_nxt = 1'b1;
        if (w_cycle_start) begin
          w_cycle_type_nxt = bus.s;
          w_count_nxt      = w_start_waits;
          w_timer_nxt      = 8'd0;
          if (w_start_waits != 4'd0) begin
            w_state_nxt = ST_WAIT;
            w_rdy1_nxt  = 1'b0;
          end else if (!bus.io_ch_rdy) begin
            w_state_nxt = ST_EXTEND;
            w_rdy1_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_DONE;
            w_rdy1_nxt  = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // The count holds the remaining forced clocks; the last one is
        // consumed on the edge that sees a count of one.
        if (r_count <= 4'd1) begin
          w_count_nxt = 4'd0;
          w_timer_nxt = 8'd0;
          if (bus.io_ch_rdy) begin
            w_state_nxt = ST_DONE;
            w_rdy1_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_EXTEND;
            w_rdy1_nxt  = 1'b0;
          end
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end

      ST_EXTEND: begin
        // Channel release wins over a timeout seen on the same edge.
        if (bus.io_ch_rdy) begin
          w_state_nxt = ST_DONE;
          w_rdy1_nxt  = 1'b1;
          w_timer_nxt = 8'd0;
        end else if (w_timer_inc == c_timeout) begin
          w_state_nxt       = ST_DONE;
          w_rdy1_nxt        = 1'b1;
          w_timer_nxt       = 8'd0;
          w_bus_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end

      ST_DONE: begin
        w_rdy1_nxt = 1'b1;
        if (bus.s == c_s_passive) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_rdy1_nxt  = 1'b1;
      end
    endcase

    w_wait_active_nxt = !w_rdy1_nxt &&
                        ((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_EXTEND));
  end

  // Sequencer state, counters and registered ready-path outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= 4'd0;
      r_timer       <= 8'd0;
      r_rdy1        <= 1'b1;
      r_wait_active <= 1'b0;
      r_cycle_type  <= c_s_passive;
      r_bus_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_timer       <= w_timer_nxt;
      r_rdy1        <= w_rdy1_nxt;
      r_wait_active <= w_wait_active_nxt;
      r_cycle_type  <= w_cycle_type_nxt;
      r_bus_timeout <= w_bus_timeout_nxt;
    end
  end

  // Previous status for edge detection and the DMA-driven ready enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_prev <= c_s_passive;
      r_aen1   <= 1'b0;
    end else begin
      r_s_prev <= bus.s;
      r_aen1   <= bus.dma_active;
    end
  end

  assign bus.rdy1        = r_rdy1;
  assign bus.aen1        = r_aen1;
  assign bus.wait_active = r_wait_active;
  assign bus.cycle_type  = r_cycle_type;
  assign bus.bus_timeout = r_bus_timeout;

endmodule
`default_nettype wire
